// File: rtl/i2c_ctrl_pkg.sv
// Shared types and constants for the I2C trigger/clock front end.
// Latency: n/a; backpressure: n/a.
package i2c_ctrl_pkg;

  localparam int CLK_DIV_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } state_t;

  // Quarter phases of one SCL bit cell: low, rise to high, high, fall to low.
  localparam logic [1:0] PH_LOW0  = 2'd0;
  localparam logic [1:0] PH_HIGH0 = 2'd1;
  localparam logic [1:0] PH_HIGH1 = 2'd2;
  localparam logic [1:0] PH_LOW1  = 2'd3;

endpackage

// File: rtl/clk_div_tick.sv
// Divides clk into a one-cycle fsm_tick, a square fsm_clk_reg and a 4-phase SCL index.
// Latency: fsm_tick is combinational from the counter; no backpressure.
module clk_div_tick
  import i2c_ctrl_pkg::*;
#(
  parameter int CLK_DIV_W = CLK_DIV_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CLK_DIV_W-1:0] clk_div_threshold,
  output logic                 fsm_tick,
  output logic                 fsm_clk_reg,
  output logic [1:0]           scl_phase
);

  logic [CLK_DIV_W-1:0] cnt;
  logic [CLK_DIV_W-1:0] thr_m1;
  logic                 wrap;

  assign thr_m1 = (clk_div_threshold == '0) ? '0 : clk_div_threshold - CLK_DIV_W'(1);

  // >= so that a threshold lowered below the running count wraps immediately.
  assign wrap     = (cnt >= thr_m1);
  assign fsm_tick = wrap & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      fsm_clk_reg <= 1'b0;
      scl_phase   <= PH_LOW0;
    end else if (wrap) begin
      cnt         <= '0;
      fsm_clk_reg <= ~fsm_clk_reg;
      scl_phase   <= scl_phase + 2'd1;
    end else begin
      cnt <= cnt + CLK_DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2c_clk_trigger_gen.sv
// Turns the host trigger bit into one phase-aligned start for the I2C FSM and tracks it to done.
// Latency: 3 clks trigger-to-edge, start on the next phase-0 tick; no backpressure.
module i2c_clk_trigger_gen
  import i2c_ctrl_pkg::*;
#(
  parameter int CLK_DIV_W     = CLK_DIV_W_DEFAULT,
  parameter int TIMEOUT_TICKS = 4096,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CLK_DIV_W-1:0] clk_div_threshold,
  input  logic [31:0]          pc_control,
  input  logic                 fsm_done,
  output logic                 fsm_tick,
  output logic                 fsm_clk_reg,
  output logic [1:0]           scl_phase,
  output logic                 start,
  output logic                 busy,
  output logic [CNT_W-1:0]     trig_count,
  output logic                 overrun,
  output logic                 timeout
);

  localparam int WD_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_TICKS - 1);

  state_t          state;
  logic [WD_W-1:0] wd_cnt;
  logic            trig_s1, trig_s2, trig_s3, trig_edge;
  logic            clr_s1, clr_s2;
  logic            done_run, wd_expire, set_overrun;
  logic            unused_pc;

  assign unused_pc = ^pc_control[31:2];

  clk_div_tick #(
    .CLK_DIV_W(CLK_DIV_W)
  ) u_div (
    .clk              (clk),
    .reset            (reset),
    .clk_div_threshold(clk_div_threshold),
    .fsm_tick         (fsm_tick),
    .fsm_clk_reg      (fsm_clk_reg),
    .scl_phase        (scl_phase)
  );

  assign busy     = (state != IDLE);
  assign done_run = (state == RUN) && fsm_done;
  // Done beats the watchdog when both land in the same cycle.
  assign wd_expire   = (state == RUN) && fsm_tick && (wd_cnt == WD_LAST) && !fsm_done;
  assign set_overrun = trig_edge && (state != IDLE) && !done_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      start      <= 1'b0;
      wd_cnt     <= '0;
      trig_count <= '0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      trig_s1    <= 1'b0;
      trig_s2    <= 1'b0;
      trig_s3    <= 1'b0;
      trig_edge  <= 1'b0;
      clr_s1     <= 1'b0;
      clr_s2     <= 1'b0;
    end else begin
      trig_s1   <= pc_control[0];
      trig_s2   <= trig_s1;
      trig_s3   <= trig_s2;
      trig_edge <= trig_s2 & ~trig_s3;
      clr_s1    <= pc_control[1];
      clr_s2    <= clr_s1;

      if (set_overrun)  overrun <= 1'b1;
      else if (clr_s2)  overrun <= 1'b0;

      if (wd_expire)    timeout <= 1'b1;
      else if (clr_s2)  timeout <= 1'b0;

      if ((state == RUN) && fsm_tick) wd_cnt <= wd_cnt + WD_W'(1);

      case (state)
        IDLE: if (trig_edge) state <= ARMED;
        ARMED: begin
          // Launch on the last quarter so start rises together with phase 0.
          if (fsm_tick && (scl_phase == PH_LOW1)) begin
            state <= START;
            start <= 1'b1;
          end
        end
        START: begin
          if (fsm_tick) begin
            state  <= RUN;
            start  <= 1'b0;
            wd_cnt <= '0;
          end
        end
        RUN: begin
          if (fsm_done) begin
            trig_count <= trig_count + CNT_W'(1);
            state      <= trig_edge ? ARMED : IDLE;
          end else if (wd_expire) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_clk_trigger_gen.sv
// Directed scenarios for i2c_clk_trigger_gen with queued expected start cycles and counts.
module tb_i2c_clk_trigger_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] thr;
  logic [31:0] pc_control;
  logic        fsm_done;
  logic        fsm_tick, fsm_clk_reg, start, busy, overrun, timeout;
  logic [1:0]  scl_phase;
  logic [15:0] trig_count;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [15:0] cnt_q[$];
  int          start_q[$];

  always #5 clk = ~clk;

  i2c_clk_trigger_gen #(
    .CLK_DIV_W    (24),
    .TIMEOUT_TICKS(8),
    .CNT_W        (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .clk_div_threshold(thr),
    .pc_control       (pc_control),
    .fsm_done         (fsm_done),
    .fsm_tick         (fsm_tick),
    .fsm_clk_reg      (fsm_clk_reg),
    .scl_phase        (scl_phase),
    .start            (start),
    .busy             (busy),
    .trig_count       (trig_count),
    .overrun          (overrun),
    .timeout          (timeout)
  );

  task automatic step;
    @(posedge clk);
    #2;
    cyc++;
  endtask

  // Cycle 1 is the first cycle after reset is sampled low.
  task automatic do_reset;
    reset = 1'b1; pc_control = '0; fsm_done = 1'b0;
    step; step;
    reset = 1'b0;
    cyc = 1;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step;
  endtask

  task automatic wait_start(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      if (start) at = cyc;
      else step;
    end
  endtask

  task automatic trigger_at2(input int exp_start);
    run_to(2);
    pc_control[0] = 1'b1;
    start_q.push_back(exp_start);
    run_to(exp_start < 8 ? 4 : 8);
    pc_control[0] = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; thr = 24'd1; pc_control = '0; fsm_done = 1'b0;
    repeat (3) step;
    #1;
    n_cmp++;
    if ({fsm_tick, fsm_clk_reg, scl_phase, start, busy, overrun, timeout} !== 8'd0) begin
      n_err++; $display("FAIL reset_outputs: got %b want 0", {fsm_tick, fsm_clk_reg, scl_phase, start, busy, overrun, timeout});
    end
    n_cmp++;
    if (trig_count !== 16'd0) begin
      n_err++; $display("FAIL reset_count: got %h want 0000", trig_count);
    end
  endtask

  task automatic test_divider;
    logic [3:0] exp;
    thr = 24'd4;
    do_reset;
    for (int k = 1; k <= 17; k++) begin
      #1;
      exp = {(k % 4 == 0), 1'(((k - 1) / 4) % 2), 2'(((k - 1) / 4) % 4)};
      n_cmp++;
      if ({fsm_tick, fsm_clk_reg, scl_phase} !== exp) begin
        n_err++; $display("FAIL div_cycle%0d: got %b want %b", k, {fsm_tick, fsm_clk_reg, scl_phase}, exp);
      end
      step;
    end
  endtask

  task automatic test_thr_edge;
    thr = 24'd0;
    do_reset;
    for (int k = 0; k < 5; k++) begin
      #1; n_cmp++;
      if (fsm_tick !== 1'b1) begin n_err++; $display("FAIL thr0_tick: got %b want 1", fsm_tick); end
      step;
    end
    thr = 24'd1;
    for (int k = 0; k < 5; k++) begin
      #1; n_cmp++;
      if (fsm_tick !== 1'b1) begin n_err++; $display("FAIL thr1_tick: got %b want 1", fsm_tick); end
      step;
    end
    thr = 24'd1000;
    do_reset;
    run_to(501);
    #1; n_cmp++;
    if (fsm_tick !== 1'b0) begin n_err++; $display("FAIL thr1000_cnt500: got %b want 0", fsm_tick); end
    thr = 24'd10;
    #1; n_cmp++;
    if (fsm_tick !== 1'b1) begin n_err++; $display("FAIL thr_lowered_tick: got %b want 1", fsm_tick); end
    step;
    #1; n_cmp++;
    if (fsm_tick !== 1'b0) begin n_err++; $display("FAIL thr_lowered_wrap: got %b want 0", fsm_tick); end
    run_to(511);
    #1; n_cmp++;
    if (fsm_tick !== 1'b1) begin n_err++; $display("FAIL thr10_period: got %b want 1", fsm_tick); end
  endtask

  task automatic test_trigger;
    int at, hi;
    thr = 24'd4;
    do_reset;
    trigger_at2(17);
    run_to(6);
    #1; n_cmp++;
    if ({busy, start} !== 2'b10) begin n_err++; $display("FAIL armed_busy: got %b want 10", {busy, start}); end
    wait_start(40, at);
    n_cmp++;
    if (at !== start_q.pop_front()) begin n_err++; $display("FAIL start_cycle: got %0d want 17", at); end
    n_cmp++;
    if ({busy, scl_phase} !== 3'b100) begin n_err++; $display("FAIL start_phase: got %b want 100", {busy, scl_phase}); end
    hi = 0;
    while (start && hi < 20) begin hi++; step; end
    n_cmp++;
    if (hi !== 4) begin n_err++; $display("FAIL start_width: got %0d want 4", hi); end
    run_to(23);
    fsm_done = 1'b1; cnt_q.push_back(16'd1);
    step;
    fsm_done = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL done_busy: got %b want 0", busy); end
    n_cmp++;
    if (trig_count !== cnt_q[0]) begin n_err++; $display("FAIL done_count: got %h want %h", trig_count, cnt_q[0]); end
    void'(cnt_q.pop_front());
  endtask

  task automatic test_overrun;
    int at, saw;
    thr = 24'd4;
    do_reset;
    trigger_at2(17);
    wait_start(40, at);
    n_cmp++;
    if (at !== start_q.pop_front()) begin n_err++; $display("FAIL ovr_start: got %0d want 17", at); end
    run_to(22);
    pc_control[0] = 1'b1;
    run_to(27);
    n_cmp++;
    if ({overrun, busy, start} !== 3'b110) begin n_err++; $display("FAIL ovr_set: got %b want 110", {overrun, busy, start}); end
    run_to(28);
    fsm_done = 1'b1; cnt_q.push_back(16'd1);
    step;
    fsm_done = 1'b0; pc_control[0] = 1'b0;
    n_cmp++;
    if ({busy, trig_count} !== {1'b0, cnt_q[0]}) begin n_err++; $display("FAIL ovr_done: got %b/%h want 0/%h", busy, trig_count, cnt_q[0]); end
    void'(cnt_q.pop_front());
    run_to(30);
    n_cmp++;
    if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    pc_control[1] = 1'b1;
    run_to(34);
    n_cmp++;
    if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    pc_control[1] = 1'b0;
    saw = 0;
    for (int k = 0; k < 24; k++) begin if (start || busy) saw = 1; step; end
    n_cmp++;
    if (saw !== 0) begin n_err++; $display("FAIL ovr_no_extra_start: got %0d want 0", saw); end
  endtask

  task automatic test_back_to_back;
    int at;
    thr = 24'd4;
    do_reset;
    trigger_at2(17);
    wait_start(40, at);
    n_cmp++;
    if (at !== start_q.pop_front()) begin n_err++; $display("FAIL b2b_start1: got %0d want 17", at); end
    run_to(22);
    pc_control[0] = 1'b1;
    run_to(25);
    fsm_done = 1'b1; cnt_q.push_back(16'd1); start_q.push_back(33);
    step;
    fsm_done = 1'b0; pc_control[0] = 1'b0;
    n_cmp++;
    if ({busy, overrun, trig_count} !== {2'b10, cnt_q[0]}) begin
      n_err++; $display("FAIL b2b_rearm: got %b/%b/%h want 1/0/%h", busy, overrun, trig_count, cnt_q[0]);
    end
    void'(cnt_q.pop_front());
    wait_start(40, at);
    n_cmp++;
    if (at !== start_q.pop_front()) begin n_err++; $display("FAIL b2b_start2: got %0d want 33", at); end
    run_to(38);
    fsm_done = 1'b1; cnt_q.push_back(16'd2);
    step;
    fsm_done = 1'b0;
    n_cmp++;
    if ({busy, trig_count} !== {1'b0, cnt_q[0]}) begin n_err++; $display("FAIL b2b_done2: got %b/%h want 0/%h", busy, trig_count, cnt_q[0]); end
    void'(cnt_q.pop_front());
    run_to(41);
    fsm_done = 1'b1;
    step;
    fsm_done = 1'b0;
    n_cmp++;
    if ({busy, trig_count} !== {1'b0, 16'd2}) begin n_err++; $display("FAIL done_in_idle: got %b/%h want 0/0002", busy, trig_count); end
  endtask

  task automatic test_timeout;
    int at;
    thr = 24'd2;
    do_reset;
    trigger_at2(9);
    wait_start(40, at);
    n_cmp++;
    if (at !== start_q.pop_front()) begin n_err++; $display("FAIL to_start: got %0d want 9", at); end
    run_to(26);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL to_still_run: got %b want 1", busy); end
    step;
    n_cmp++;
    if ({busy, timeout, overrun, trig_count} !== {3'b010, 16'd0}) begin
      n_err++; $display("FAIL to_abort: got %b/%b/%b/%h want 0/1/0/0000", busy, timeout, overrun, trig_count);
    end
    pc_control[1] = 1'b1;
    run_to(31);
    n_cmp++;
    if (timeout !== 1'b0) begin n_err++; $display("FAIL to_clear: got %b want 0", timeout); end
    pc_control[1] = 1'b0;
    do_reset;
    trigger_at2(9);
    wait_start(40, at);
    n_cmp++;
    if (at !== start_q.pop_front()) begin n_err++; $display("FAIL to2_start: got %0d want 9", at); end
    run_to(26);
    fsm_done = 1'b1; cnt_q.push_back(16'd1);
    step;
    fsm_done = 1'b0;
    n_cmp++;
    if ({busy, timeout, trig_count} !== {2'b00, cnt_q[0]}) begin
      n_err++; $display("FAIL done_beats_wd: got %b/%b/%h want 0/0/%h", busy, timeout, trig_count, cnt_q[0]);
    end
    void'(cnt_q.pop_front());
  endtask

  task automatic test_reset_mid;
    int at;
    thr = 24'd4;
    do_reset;
    trigger_at2(17);
    wait_start(40, at);
    n_cmp++;
    if (at !== start_q.pop_front()) begin n_err++; $display("FAIL rm_start: got %0d want 17", at); end
    run_to(18);
    reset = 1'b1;
    step;
    n_cmp++;
    if ({start, busy} !== 2'b00) begin n_err++; $display("FAIL rm_drop: got %b want 00", {start, busy}); end
    reset = 1'b0;
    cyc = 1;
    force dut.trig_count = 16'hFFFF;
    step;
    release dut.trig_count;
    pc_control[0] = 1'b1;
    start_q.push_back(17);
    step;
    n_cmp++;
    if (trig_count !== 16'hFFFF) begin n_err++; $display("FAIL rm_preload: got %h want ffff", trig_count); end
    run_to(8);
    pc_control[0] = 1'b0;
    wait_start(40, at);
    n_cmp++;
    if (at !== start_q.pop_front()) begin n_err++; $display("FAIL rm_start2: got %0d want 17", at); end
    run_to(23);
    fsm_done = 1'b1; cnt_q.push_back(16'h0000);
    step;
    fsm_done = 1'b0;
    n_cmp++;
    if ({busy, trig_count} !== {1'b0, cnt_q[0]}) begin n_err++; $display("FAIL count_wrap: got %b/%h want 0/%h", busy, trig_count, cnt_q[0]); end
    void'(cnt_q.pop_front());
  endtask

  initial begin
    test_reset;
    test_divider;
    test_thr_edge;
    test_trigger;
    test_overrun;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
